// File: rtl/echo_ranger_pkg.sv
// Shared definitions for the multi-channel echo ranger: FSM states,
// a width helper and the saturation constant.
package echo_ranger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_REPORT,
    ST_GAP
  } state_t;

  // Counter and data values use the low bits of this pattern.
  localparam logic [31:0] SAT_ALL = '1;

  // $clog2 with a floor of one bit, so one- and two-entry indices still have a wire.
  function automatic int min1_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/echo_tick_gen.sv
// Measurement tick divider: one-cycle tick every TICK_DIV clocks,
// restarted from zero whenever the controller changes state.
module echo_tick_gen
  import echo_ranger_pkg::*;
#(
  parameter int TICK_DIV = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int DW = min1_clog2(TICK_DIV);
  localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] r_div;

  assign o_tick = (r_div == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
    end else if (i_restart || o_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/echo_ranger_mc.sv
// Round-robin ultrasonic ranging engine: triggers each enabled sensor in turn,
// times its echo in ticks and hands each result out on a valid/ready stream.
module echo_ranger_mc
  import echo_ranger_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 16,
  parameter int TICK_DIV      = 20,
  parameter int TRIG_TICKS    = 10,
  parameter int TIMEOUT_TICKS = 30000,
  parameter int GAP_TICKS     = 60000
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_enable,
  input  logic [NUM_CH-1:0]               i_ch_mask,
  input  logic [NUM_CH-1:0]               i_echo,
  output logic [NUM_CH-1:0]               o_trig,
  output logic [CNT_W-1:0]                o_dist_data,
  output logic [min1_clog2(NUM_CH)-1:0]   o_dist_ch,
  output logic                            o_dist_to,
  output logic                            o_dist_valid,
  input  logic                            i_dist_ready,
  output logic                            o_busy
);

  localparam int CH_W = min1_clog2(NUM_CH);
  localparam logic [CNT_W-1:0] SAT          = CNT_W'(SAT_ALL);
  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_TICKS - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_data;
  logic                r_to;
  logic [CH_W-1:0]     r_ch;
  logic [CH_W-1:0]     r_ptr;
  logic [CH_W-1:0]     w_sel_ch;
  logic [CH_W-1:0]     w_idx;
  logic                w_found;
  logic                w_tick;
  logic                w_restart;
  logic [NUM_CH-1:0]   r_echo_meta;
  logic [NUM_CH-1:0]   r_echo_sync;
  logic [NUM_CH-1:0]   r_echo_prev;
  logic [NUM_CH-1:0]   w_rise_vec;
  logic [NUM_CH-1:0]   w_fall_vec;
  logic                w_rise;
  logic                w_fall;

  // Any state change restarts both the divider and the tick counter.
  assign w_restart = (w_state_next != r_state);

  echo_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_echo_meta <= '0;
      r_echo_sync <= '0;
      r_echo_prev <= '0;
    end else begin
      r_echo_meta <= i_echo;
      r_echo_sync <= r_echo_meta;
      r_echo_prev <= r_echo_sync;
    end
  end

  assign w_rise_vec = r_echo_sync & ~r_echo_prev;
  assign w_fall_vec = ~r_echo_sync & r_echo_prev;
  assign w_rise     = w_rise_vec[r_ch];
  assign w_fall     = w_fall_vec[r_ch];

  // First enabled channel at or after the pointer, wrapping around.
  always_comb begin
    w_found  = 1'b0;
    w_sel_ch = r_ptr;
    w_idx    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = CH_W'((int'(r_ptr) + k) % NUM_CH);
      if (!w_found && i_ch_mask[w_idx]) begin
        w_found  = 1'b1;
        w_sel_ch = w_idx;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_enable && (i_ch_mask != '0)) w_state_next = ST_SELECT;
      end
      ST_SELECT: begin
        w_state_next = w_found ? ST_TRIG : ST_IDLE;
      end
      ST_TRIG: begin
        if (w_tick && (r_cnt == TRIG_LAST)) w_state_next = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (w_rise)                                   w_state_next = ST_MEASURE;
        else if (w_tick && (r_cnt == TIMEOUT_LAST))   w_state_next = ST_REPORT;
      end
      ST_MEASURE: begin
        if (w_fall || (w_tick && (r_cnt == TIMEOUT_LAST))) w_state_next = ST_REPORT;
      end
      ST_REPORT: begin
        if (i_dist_ready) w_state_next = ST_GAP;
      end
      ST_GAP: begin
        if (w_tick && (r_cnt == GAP_LAST)) w_state_next = i_enable ? ST_SELECT : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
      r_data  <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_restart) begin
        r_cnt <= '0;
      end else if (w_tick && (r_cnt != SAT)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if ((r_state == ST_SELECT) && w_found) begin
        r_ch <= w_sel_ch;
      end

      if ((r_state == ST_GAP) && w_restart) begin
        r_ptr <= (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + 1'b1;
      end

      // Result is frozen on REPORT entry and held until the next one.
      if ((w_state_next == ST_REPORT) && (r_state != ST_REPORT)) begin
        if ((r_state == ST_MEASURE) && w_fall) begin
          r_data <= r_cnt;
          r_to   <= 1'b0;
        end else begin
          r_data <= SAT;
          r_to   <= 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_trig
    assign o_trig[gi] = (r_state == ST_TRIG) && (r_ch == CH_W'(gi));
  end

  assign o_dist_valid = (r_state == ST_REPORT);
  assign o_dist_data  = r_data;
  assign o_dist_ch    = r_ch;
  assign o_dist_to    = r_to;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_echo_ranger_mc.sv
// Directed bench for echo_ranger_mc: table of per-channel measurements plus
// hand sequences for backpressure, enable drop, empty mask and reset.
module tb_echo_ranger_mc;

  logic        clk;
  logic        rst_n;
  logic        din_enable;
  logic [3:0]  din_mask;
  logic [3:0]  din_echo;
  logic        din_ready;
  logic [3:0]  dut_trig;
  logic [15:0] dut_data;
  logic [1:0]  dut_ch;
  logic        dut_to;
  logic        dut_valid;
  logic        dut_busy;

  int total = 0;
  int bad   = 0;

  echo_ranger_mc #(
    .NUM_CH        (4),
    .CNT_W         (16),
    .TICK_DIV      (2),
    .TRIG_TICKS    (3),
    .TIMEOUT_TICKS (50),
    .GAP_TICKS     (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (din_enable),
    .i_ch_mask    (din_mask),
    .i_echo       (din_echo),
    .o_trig       (dut_trig),
    .o_dist_data  (dut_data),
    .o_dist_ch    (dut_ch),
    .o_dist_to    (dut_to),
    .o_dist_valid (dut_valid),
    .i_dist_ready (din_ready),
    .o_busy       (dut_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    int         exp_ch;
    int         echo_clks;   // 0: no echo at all
    bit         pre_high;    // echo already high before the trigger
    int         lo;
    int         hi;
    bit         exp_to;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input logic [31:0] act, input int lo, input int hi);
    total++;
    if ((^act === 1'bx) || (act < 32'(lo)) || (act > 32'(hi))) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // TRIG must never be wider than one bit.
  always @(negedge clk) begin
    if (rst_n && (dut_trig != 4'b0000)) begin
      total++;
      if ($countones(dut_trig) != 1) begin
        bad++;
        $display("FAIL trig_onehot_mon: got %b want one-hot", dut_trig);
      end
    end
  end

  task automatic trig_phase(input int exp_ch, output bit ok);
    int n;
    int seen;
    n = 0;
    while ((dut_trig == 4'b0000) && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    ok = (dut_trig != 4'b0000);
    check("trig_seen", 32'(ok), 1);
    if (!ok) return;
    seen = -1;
    for (int i = 0; i < 4; i++) if (dut_trig[i]) seen = i;
    check("trig_ch", seen, exp_ch);
    n = 0;
    while ((dut_trig != 4'b0000) && (n < 100)) begin
      n++;
      @(negedge clk);
    end
    check("trig_len", n, 6);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int n;
    n = 0;
    while (!dut_valid && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    ok = dut_valid;
    check("valid_seen", 32'(ok), 1);
  endtask

  task automatic do_channel(input int idx, input vec_t v);
    bit ok;
    din_mask = v.mask;
    if (v.pre_high) din_echo[v.exp_ch] = 1'b1;
    trig_phase(v.exp_ch, ok);
    if (!ok) begin
      din_echo = 4'b0000;
      return;
    end
    if (v.echo_clks > 0) begin
      repeat (4) @(negedge clk);
      din_echo[v.exp_ch] = 1'b1;
      for (int n = 0; (n < v.echo_clks) && !dut_valid; n++) @(negedge clk);
      if (!dut_valid) din_echo[v.exp_ch] = 1'b0;
    end
    wait_valid(300, ok);
    if (ok) begin
      check_range("dist_data", dut_data, v.lo, v.hi);
      check("dist_ch", dut_ch, v.exp_ch);
      check("dist_to", dut_to, v.exp_to);
      $display("vec %0d: ch=%0d data=%0d to=%0d", idx, dut_ch, dut_data, dut_to);
      @(negedge clk);
      check("valid_pulse", dut_valid, 0);
    end
    din_echo = 4'b0000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    int   n;
    vec_t rv;

    // Echo width W clocks is expected as W/2 ticks, within one tick.
    vecs[0] = '{4'b0001, 0,  40, 1'b0, 19,    21,    1'b0};
    vecs[1] = '{4'b1010, 1,  14, 1'b0, 6,     8,     1'b0};
    vecs[2] = '{4'b1010, 3,  18, 1'b0, 8,     10,    1'b0};
    vecs[3] = '{4'b1010, 1,  10, 1'b0, 4,     6,     1'b0};
    vecs[4] = '{4'b0100, 2,  0,  1'b0, 65535, 65535, 1'b1};
    vecs[5] = '{4'b1111, 3,  4,  1'b0, 1,     3,     1'b0};
    vecs[6] = '{4'b0001, 0,  98, 1'b0, 48,    50,    1'b0};
    vecs[7] = '{4'b1000, 3, 120, 1'b0, 65535, 65535, 1'b1};
    vecs[8] = '{4'b0010, 1,  0,  1'b1, 65535, 65535, 1'b1};

    rst_n      = 1'b0;
    din_enable = 1'b0;
    din_mask   = 4'b0000;
    din_echo   = 4'b0000;
    din_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_trig",  dut_trig,  0);
    check("rst_valid", dut_valid, 0);
    check("rst_data",  dut_data,  0);
    check("rst_ch",    dut_ch,    0);
    check("rst_to",    dut_to,    0);
    check("rst_busy",  dut_busy,  0);
    rst_n = 1'b1;
    @(negedge clk);

    din_enable = 1'b1;
    for (int i = 0; i < 9; i++) do_channel(i, vecs[i]);

    // Backpressure: result held untouched and no new trigger while READY is low.
    din_ready = 1'b0;
    din_mask  = 4'b0001;
    trig_phase(0, ok);
    repeat (4) @(negedge clk);
    din_echo[0] = 1'b1;
    repeat (20) @(negedge clk);
    din_echo[0] = 1'b0;
    wait_valid(300, ok);
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!(dut_valid && (dut_data >= 16'd9) && (dut_data <= 16'd11) &&
            (dut_ch == 2'd0) && !dut_to && (dut_trig == 4'b0000))) ok = 1'b0;
      @(negedge clk);
    end
    check("bp_hold", 32'(ok), 1);
    $display("backpressure: ch=%0d data=%0d to=%0d", dut_ch, dut_data, dut_to);
    din_ready = 1'b1;
    @(negedge clk);
    check("bp_release", dut_valid, 0);
    check("bp_busy_gap", dut_busy, 1);

    // ENABLE dropped mid-measurement: result still delivered, then idle.
    trig_phase(0, ok);
    repeat (4) @(negedge clk);
    din_echo[0] = 1'b1;
    repeat (10) @(negedge clk);
    din_enable = 1'b0;
    repeat (10) @(negedge clk);
    din_echo[0] = 1'b0;
    wait_valid(300, ok);
    check_range("en_drop_data", dut_data, 9, 11);
    check("en_drop_to", dut_to, 0);
    $display("enable drop: ch=%0d data=%0d to=%0d", dut_ch, dut_data, dut_to);
    @(negedge clk);
    n = 0;
    while (dut_busy && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    check("busy_clear", dut_busy, 0);
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (dut_busy || (dut_trig != 4'b0000)) ok = 1'b0;
      @(negedge clk);
    end
    check("idle_after_drop", 32'(ok), 1);

    // Empty mask with ENABLE high never leaves IDLE.
    din_mask   = 4'b0000;
    din_enable = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dut_busy || dut_valid || (dut_trig != 4'b0000)) ok = 1'b0;
    end
    check("empty_mask", 32'(ok), 1);
    $display("empty mask: busy=%0d trig=%b", dut_busy, dut_trig);

    // Reset during TRIG clears outputs at once; scan restarts at channel 0.
    din_mask = 4'b0100;
    n = 0;
    while ((dut_trig == 4'b0000) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_trig", dut_trig, 4'b0100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_trig",  dut_trig,  0);
    check("async_rst_valid", dut_valid, 0);
    check("async_rst_busy",  dut_busy,  0);
    check("async_rst_ch",    dut_ch,    0);
    $display("reset in trig: trig=%b valid=%0d busy=%0d", dut_trig, dut_valid, dut_busy);
    @(negedge clk);
    din_mask = 4'b1111;
    rst_n    = 1'b1;
    rv = '{4'b1111, 0, 6, 1'b0, 2, 4, 1'b0};
    do_channel(9, rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
